// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave peripheral.
// Holds the register offsets, the STATUS/CTRL bit positions and the
// FSM state encoding so the RTL and any software-facing views agree.
package spi_slave_pkg;

  localparam logic [3:0] ADDR_TXDATA = 4'h0;
  localparam logic [3:0] ADDR_RXDATA = 4'h2;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h6;

  localparam int STAT_RX_VALID = 0;
  localparam int STAT_TX_FULL  = 1;
  localparam int STAT_OVERRUN  = 2;
  localparam int STAT_BUSY     = 3;

  localparam int CTRL_ENABLE  = 0;
  localparam int CTRL_CLR_OVR = 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for one asynchronous input, with single-cycle
// rise/fall pulses derived from the synchronized level.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset (clears all stages)
//   d    - asynchronous input
//   q    - synchronized level
//   rise - one-cycle pulse on a 0->1 transition of q
//   fall - one-cycle pulse on a 1->0 transition of q
module spi_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta;
  logic q_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
      q_d  <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
      q_d  <= q;
    end
  end

  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/peripheral_spi_slave.sv
// SPI mode-0 slave with a small register interface on the J1 bus.
// Ports:
//   clk, rst          - system clock, synchronous active-high reset
//   d_in, cs, addr,
//   rd, wr            - register bus (only d_in[7:0] is used)
//   d_out             - registered read data (1-cycle latency)
//   sck, ss, mosi     - SPI inputs, asynchronous to clk
//   miso              - SPI output, 0 while idle
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no frame; miso held at 0, waiting for ss fall with enable
// ST_SHIFT | frame active; shifting on synchronized sck edges
module peripheral_spi_slave
  import spi_slave_pkg::*;
#(
  parameter int         FRAME_BITS = 8,
  parameter logic [7:0] IDLE_BYTE  = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [3:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] d_out,
  input  logic        sck,
  input  logic        ss,
  input  logic        mosi,
  output logic        miso
);

  localparam int                CNT_W    = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FRAME_BITS - 1);

  logic unused_sck_level;
  logic sck_rise, sck_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_meta, mosi_s;

  spi_sync u_sync_sck (
    .clk  (clk),
    .rst  (rst),
    .d    (sck),
    .q    (unused_sck_level),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  spi_sync u_sync_ss (
    .clk  (clk),
    .rst  (rst),
    .d    (ss),
    .q    (ss_s),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  // mosi shares the sck latency so the sample lines up with sck_rise
  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
    end else begin
      mosi_meta <= mosi;
      mosi_s    <= mosi_meta;
    end
  end

  state_t           state;
  logic [7:0]       shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic             reload_pend;
  logic [7:0]       tx_hold;
  logic             tx_full;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             overrun;
  logic             enable;

  logic unused_d_in_hi;
  assign unused_d_in_hi = ^d_in[15:8];

  logic tx_wr, ctrl_wr, rx_rd, rd_sel;
  assign rd_sel  = cs & rd;
  assign tx_wr   = cs & wr & (addr == ADDR_TXDATA);
  assign ctrl_wr = cs & wr & (addr == ADDR_CTRL);
  assign rx_rd   = rd_sel & (addr == ADDR_RXDATA);

  logic [7:0] rx_next;
  logic [7:0] load_byte;
  logic       entry, reload, tx_take, byte_done;

  assign rx_next   = {shreg[6:0], mosi_s};
  assign load_byte = tx_full ? tx_hold : IDLE_BYTE;
  assign entry     = (state == ST_IDLE) & ss_fall & enable;
  // ss rising takes priority over any sck edge seen in the same cycle
  assign reload    = (state == ST_SHIFT) & ~ss_rise & sck_fall & reload_pend;
  assign tx_take   = (entry | reload) & tx_full;
  assign byte_done = (state == ST_SHIFT) & ~ss_rise & sck_rise & (bit_cnt == LAST_BIT);

  logic [15:0] status_word;
  logic [15:0] rd_data;

  always_comb begin
    status_word                = 16'h0000;
    status_word[STAT_RX_VALID] = rx_valid;
    status_word[STAT_TX_FULL]  = tx_full;
    status_word[STAT_OVERRUN]  = overrun;
    status_word[STAT_BUSY]     = ~ss_s;
  end

  always_comb begin
    rd_data = 16'h0000;
    case (addr)
      ADDR_RXDATA: rd_data = {8'h00, rx_data};
      ADDR_STATUS: rd_data = status_word;
      default:     rd_data = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      shreg       <= 8'h00;
      bit_cnt     <= '0;
      reload_pend <= 1'b0;
      miso        <= 1'b0;
      tx_hold     <= 8'h00;
      tx_full     <= 1'b0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      overrun     <= 1'b0;
      enable      <= 1'b0;
      d_out       <= 16'h0000;
    end else begin
      if (ctrl_wr)
        enable <= d_in[CTRL_ENABLE];

      // tx_take needs tx_full=1, which also blocks a write, so the two never collide
      if (tx_take) begin
        tx_full <= 1'b0;
      end else if (tx_wr && !tx_full) begin
        tx_hold <= d_in[7:0];
        tx_full <= 1'b1;
      end

      if (rd_sel)
        d_out <= rd_data;

      // completion beats a simultaneous read: the reader gets the old byte
      if (byte_done) begin
        rx_data  <= rx_next;
        rx_valid <= 1'b1;
      end else if (rx_rd) begin
        rx_valid <= 1'b0;
      end

      if (ctrl_wr && d_in[CTRL_CLR_OVR])
        overrun <= 1'b0;
      else if (byte_done && rx_valid && !rx_rd)
        overrun <= 1'b1;

      case (state)
        ST_IDLE: begin
          miso        <= 1'b0;
          bit_cnt     <= '0;
          reload_pend <= 1'b0;
          if (entry) begin
            state <= ST_SHIFT;
            shreg <= load_byte;
            miso  <= load_byte[7];
          end
        end
        ST_SHIFT: begin
          if (ss_rise) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
            miso        <= 1'b0;
          end else if (sck_rise) begin
            shreg   <= rx_next;
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == LAST_BIT) begin
              if (!enable) begin
                state <= ST_IDLE;
                miso  <= 1'b0;
              end else begin
                reload_pend <= 1'b1;
              end
            end
          end else if (sck_fall) begin
            if (reload_pend) begin
              shreg       <= load_byte;
              miso        <= load_byte[7];
              reload_pend <= 1'b0;
            end else begin
              miso <= shreg[7];
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_spi_slave.sv
// Self-checking bench for peripheral_spi_slave: table of full frames plus
// hand-written sequences for partial frames, read/complete collision and reset.
module tb_peripheral_spi_slave;
  import spi_slave_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] d_in;
  logic        cs, rd, wr;
  logic [3:0]  addr;
  logic [15:0] d_out;
  logic        sck, ss, mosi, miso;

  int n_cmp = 0;
  int n_bad = 0;

  peripheral_spi_slave #(.FRAME_BITS(8), .IDLE_BYTE(8'hFF)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
    .d_out(d_out), .sck(sck), .ss(ss), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [15:0] d);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    d = d_out;
  endtask

  // sck half period = 4 clk cycles, i.e. sck = clk/8
  task automatic ss_low(input logic b0);
    @(negedge clk);
    mosi = b0; ss = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic spi_bit(input logic next_bit, input bit coread,
                         output logic sampled, output logic [15:0] cv);
    cv = 16'h0000;
    sampled = miso;
    sck = 1'b1;
    // rd lands on the clk edge where the DUT registers the 8th rising edge
    repeat (2) @(negedge clk);
    if (coread) begin cs = 1'b1; rd = 1'b1; addr = ADDR_RXDATA; end
    @(negedge clk);
    if (coread) begin cs = 1'b0; rd = 1'b0; cv = d_out; end
    @(negedge clk);
    sck = 1'b0;
    mosi = next_bit;
    repeat (4) @(negedge clk);
  endtask

  task automatic ss_high();
    ss = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic spi_frame(input logic [7:0] tx, input int nbits, input bit coread,
                           output logic [7:0] got, output logic [15:0] cv);
    logic        s;
    logic [15:0] c;
    logic        nb;
    got = 8'h00;
    cv  = 16'h0000;
    ss_low(tx[7]);
    for (int i = 0; i < nbits; i++) begin
      nb = (i < 7) ? tx[6-i] : 1'b0;
      spi_bit(nb, coread && (i == 7), s, c);
      got[7-i] = s;
      if (coread && i == 7) cv = c;
    end
    ss_high();
  endtask

  typedef struct {
    bit          tx_en;
    logic [7:0]  tx_byte;
    logic [15:0] exp_pre;
    logic [7:0]  mosi_byte;
    logic [7:0]  exp_miso;
    logic [15:0] exp_status;
    bit          read_rx;
    logic [15:0] exp_rx;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [15:0] r;
    logic [15:0] cv;
    logic [7:0]  got;

    vecs[0] = '{1'b1, 8'hA5, 16'h0002, 8'h3C, 8'hA5, 16'h0001, 1'b1, 16'h003C};
    vecs[1] = '{1'b0, 8'h00, 16'h0000, 8'h00, 8'hFF, 16'h0001, 1'b1, 16'h0000};
    vecs[2] = '{1'b0, 8'h00, 16'h0000, 8'h11, 8'hFF, 16'h0001, 1'b0, 16'h0000};
    vecs[3] = '{1'b1, 8'hE7, 16'h0003, 8'h22, 8'hE7, 16'h0005, 1'b1, 16'h0022};

    rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 4'h0; d_in = 16'h0000;
    sck = 1'b0; ss = 1'b1; mosi = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    check("reset_d_out", d_out, 16'h0000);
    check("reset_miso", {15'h0, miso}, 16'h0000);
    repeat (4) @(negedge clk);
    bus_read(ADDR_STATUS, r);
    check("reset_status", r, 16'h0000);
    bus_read(4'hA, r);
    check("unmapped_read", r, 16'h0000);

    bus_write(ADDR_CTRL, 16'h0001);

    for (int i = 0; i < 4; i++) begin
      if (vecs[i].tx_en) begin
        bus_write(ADDR_TXDATA, {8'h00, vecs[i].tx_byte});
        bus_write(ADDR_TXDATA, {8'h00, ~vecs[i].tx_byte});
        bus_read(ADDR_STATUS, r);
        check($sformatf("v%0d_pre_status", i), r, vecs[i].exp_pre);
      end
      spi_frame(vecs[i].mosi_byte, 8, 1'b0, got, cv);
      check($sformatf("v%0d_miso", i), {8'h00, got}, {8'h00, vecs[i].exp_miso});
      bus_read(ADDR_STATUS, r);
      check($sformatf("v%0d_status", i), r, vecs[i].exp_status);
      if (vecs[i].read_rx) begin
        bus_read(ADDR_RXDATA, r);
        check($sformatf("v%0d_rxdata", i), r, vecs[i].exp_rx);
      end
    end

    bus_write(ADDR_CTRL, 16'h0003);
    bus_read(ADDR_STATUS, r);
    check("ovr_clear_status", r, 16'h0000);

    spi_frame(8'h77, 5, 1'b0, got, cv);
    bus_read(ADDR_STATUS, r);
    check("partial_status", r, 16'h0000);
    bus_read(ADDR_RXDATA, r);
    check("partial_rxdata", r, 16'h0022);
    spi_frame(8'h5A, 8, 1'b0, got, cv);
    bus_read(ADDR_RXDATA, r);
    check("after_partial_rx", r, 16'h005A);

    spi_frame(8'h66, 8, 1'b0, got, cv);
    bus_read(ADDR_STATUS, r);
    check("pre_coread_status", r, 16'h0001);
    spi_frame(8'h99, 8, 1'b1, got, cv);
    check("coread_old_byte", cv, 16'h0066);
    bus_read(ADDR_STATUS, r);
    check("coread_status", r, 16'h0001);
    bus_read(ADDR_RXDATA, r);
    check("coread_new_rx", r, 16'h0099);

    bus_write(ADDR_TXDATA, 16'h00C3);
    ss_low(1'b1);
    for (int i = 0; i < 4; i++) spi_bit(1'b0, 1'b0, got[0], cv);
    bus_read(ADDR_STATUS, r);
    check("midframe_status", r, 16'h0008);
    @(negedge clk);
    rst = 1'b1; ss = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_d_out", d_out, 16'h0000);
    check("rst_mid_miso", {15'h0, miso}, 16'h0000);
    repeat (4) @(negedge clk);
    bus_read(ADDR_STATUS, r);
    check("rst_mid_status", r, 16'h0000);

    spi_frame(8'h81, 8, 1'b0, got, cv);
    check("disabled_miso", {8'h00, got}, 16'h0000);
    bus_read(ADDR_STATUS, r);
    check("disabled_status", r, 16'h0000);

    bus_write(ADDR_CTRL, 16'h0001);
    spi_frame(8'h81, 8, 1'b0, got, cv);
    check("post_rst_miso", {8'h00, got}, 16'h00FF);
    bus_read(ADDR_RXDATA, r);
    check("post_rst_rx", r, 16'h0081);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
